ifetch_ctrl: RTL and testbench
==============================

# ifetch_ctrl

Instruction-fetch controller that owns the fetch address and produces the `pc_in`/`stall` pair consumed by the PC register. It issues word fetches to instruction memory over a req/ready handshake, buffers returned instructions in a small queue toward decode, and handles branch/jump redirects, including redirects that arrive while a fetch is outstanding. All state is updated on the rising edge. `pc_next`/`pc_stall` are registered so the PC register, which samples on the falling edge, always sees stable values.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset. Must match the PC register's reset value.
- `QDEPTH`, default 2: instruction queue depth, ≥1.
- `clk`  in  1  clock; all state on posedge.
- `reset`  in  1  reset, synchronous, active-high.
- `pc_next`  out  32  to PC register `pc_in`; address of the most recently issued fetch.
- `pc_stall`  out  1  to PC register `stall`; 0 for exactly one cycle after each new fetch address is committed.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address, equal to `fetch_pc`; stable while `imem_req`=1.
- `imem_ready`  in  1  response strobe; `imem_rdata` is valid in the same cycle; only legal while `imem_req`=1.
- `imem_rdata`  in  32  fetched instruction.
- `redirect_valid`  in  1  one-cycle redirect pulse from the branch/jump resolution stage.
- `redirect_pc`  in  32  redirect target; bits [1:0] are forced to 0 internally.
- `id_stall`  in  1  decode cannot accept this cycle.
- `inst_valid`  out  1  queue head valid; forced 0 in any cycle where `redirect_valid`=1.
- `inst_out`  out  32  queue head instruction.
- `inst_pc`  out  32  address of `inst_out`.

## Operation
- Internal state: `fetch_pc`, FSM state (REQ, HOLD), `discard` flag, `redir_pc`, and a FIFO of {pc, inst} with depth QDEPTH.
- Pop condition: `inst_valid && !id_stall`.
- REQ state: `imem_req`=1.
  - On `imem_ready` with `discard`=0 and no redirect, push {fetch_pc, imem_rdata}, then `fetch_pc <= fetch_pc+4` (32-bit wrap).
  - After the push, go to HOLD if the queue is full after the cycle's push and pop; otherwise stay in REQ.
- HOLD state: `imem_req`=0. On a pop, go to REQ next cycle. `fetch_pc` is already advanced.
- Redirect rules:
  - Redirect in HOLD, or in REQ with `imem_ready`=1: flush the queue, `fetch_pc <= redirect_pc`, go to REQ, discard any same-cycle data.
  - Redirect in REQ with `imem_ready`=0: flush the queue, set `discard`=1, `redir_pc <= redirect_pc`. `imem_addr` is held.
  - Redirect while `discard`=1: `redir_pc` is overwritten (latest wins).
- Response in REQ while `discard`=1 and no new redirect: drop the data, `fetch_pc <= redir_pc`, clear `discard`.
- Flush beats push and pop in the same cycle. The queue is empty the cycle after a redirect.
- Each time `fetch_pc` is written, with a new value or an equal one:
  - `pc_next <= new fetch_pc`
  - `pc_stall <= 0` for the following cycle, otherwise `pc_stall <= 1`.
- Reset (also mid-transaction):
  - `fetch_pc`, `pc_next` = RESET_PC; state = REQ; `discard` = 0; queue empty; `pc_stall` = 1.
  - Any outstanding memory transaction is abandoned.
  - Outputs in the first post-reset cycle: `imem_req`=1, `imem_addr`=RESET_PC, `inst_valid`=0.

## Timing
- Fetch throughput: one instruction per cycle when `imem_ready` is tied high and `id_stall`=0.
- Latency from `imem_ready` to `inst_valid`: one cycle. Data is pushed at the posedge and visible after it.
- Latency from `imem_ready` to PC update:
  - Posedge t: `pc_next`/`pc_stall` update.
  - Following negedge: the PC register loads `pc_next`.
- Redirect, no outstanding request: `imem_addr` = target in the cycle after the redirect.
- Redirect with an outstanding request: target issued in the cycle after the pending response.
- `imem_addr` never changes while `imem_req`=1 and `imem_ready`=0.

## Test plan
- Reset release, `imem_ready`=1, `id_stall`=0 → `imem_addr` 0,4,8,C on consecutive cycles. `inst_pc` follows one cycle later. `pc_stall` is low each cycle and `pc_next` tracks the addresses.
- `id_stall`=1 held, QDEPTH=2 → two pushes (pc 0, 4), then HOLD with `imem_req`=0 and `fetch_pc`=8. Release `id_stall` → pops pc 0 and pc 4; REQ at 8 on the cycle after the first pop.
- `imem_ready` delayed 3 cycles, redirect to 0x100 in the first wait cycle → `imem_addr` held at the old address. The response is dropped and no push occurs. The next `imem_addr` is 0x100.
- Two redirects (0x200, then 0x300) during one outstanding fetch → 0x300 is issued; 0x200 is never fetched.
- Redirect to 0x400 with `imem_ready` and a pop in the same cycle, queue holding 1 entry → `inst_valid`=0 that cycle. Queue empty next cycle, `imem_addr`=0x400, `pc_next`=0x400.
- Wrap and reset:
  - `redirect_pc`=0xFFFF_FFFE → fetch at 0xFFFF_FFFC, then 0x0.
  - Assert `reset` mid-wait → next cycle `imem_addr`=RESET_PC and queue empty.

Source files
------------

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: fetch address owner, imem req/ready sequencing, redirect handling and decode-side instruction queue
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_next,
    output logic        pc_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc
);
    localparam int PW = QDEPTH > 1 ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);
    localparam logic [PW-1:0] LAST = PW'(QDEPTH - 1);
    typedef enum logic {REQ, HOLD} state_t;
    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d, redir_pc_q, redir_pc_d, pc_next_q, rpc;
    logic          discard_q, discard_d, pc_stall_q, pc_wr, resp, push, pop;
    logic [31:0]   qpc_q [QDEPTH];
    logic [31:0]   qinst_q [QDEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    assign rpc        = redirect_pc & ~32'd3;
    assign imem_req   = state_q == REQ;
    assign imem_addr  = fetch_pc_q;
    assign pc_next    = pc_next_q;
    assign pc_stall   = pc_stall_q;
    assign inst_valid = cnt_q != '0 && !redirect_valid;
    assign inst_out   = qinst_q[rd_q];
    assign inst_pc    = qpc_q[rd_q];
    assign resp       = imem_req && imem_ready;
    assign push       = resp && !discard_q && !redirect_valid;
    assign pop        = inst_valid && !id_stall;
    assign cnt_d      = redirect_valid ? '0 : cnt_q + CW'(push) - CW'(pop);
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        redir_pc_d = redir_pc_q;
        discard_d  = discard_q;
        pc_wr      = 1'b0;
        if (redirect_valid) begin
            if (state_q == HOLD || imem_ready) begin
                fetch_pc_d = rpc;
                pc_wr      = 1'b1;
                state_d    = REQ;
                discard_d  = 1'b0;
            end else begin
                discard_d  = 1'b1;
                redir_pc_d = rpc;
            end
        end else if (resp && discard_q) begin
            fetch_pc_d = redir_pc_q;
            pc_wr      = 1'b1;
            discard_d  = 1'b0;
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            pc_wr      = 1'b1;
            state_d    = cnt_d == FULL ? HOLD : REQ;
        end else if (state_q == HOLD && pop) begin
            state_d = REQ;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= REQ;
            fetch_pc_q <= RESET_PC;
            redir_pc_q <= RESET_PC;
            discard_q  <= 1'b0;
            pc_next_q  <= RESET_PC;
            pc_stall_q <= 1'b1;
            rd_q       <= '0;
            wr_q       <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            redir_pc_q <= redir_pc_d;
            discard_q  <= discard_d;
            pc_next_q  <= pc_wr ? fetch_pc_d : pc_next_q;
            pc_stall_q <= !pc_wr;
            cnt_q      <= cnt_d;
            wr_q       <= redirect_valid ? '0 : push ? (wr_q == LAST ? '0 : wr_q + 1'b1) : wr_q;
            rd_q       <= redirect_valid ? '0 : pop ? (rd_q == LAST ? '0 : rd_q + 1'b1) : rd_q;
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            qpc_q[wr_q]   <= fetch_pc_q;
            qinst_q[wr_q] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed scenario tasks for ifetch_ctrl with inline hand-computed checks
module tb_ifetch_ctrl;
    logic        clk = 1'b0, reset = 1'b1;
    logic [31:0] pc_next, imem_addr, inst_out, inst_pc;
    logic        pc_stall, imem_req, inst_valid;
    logic        imem_ready = 1'b0, redirect_valid = 1'b0, id_stall = 1'b0;
    logic [31:0] imem_rdata = '0, redirect_pc = '0;
    int          n_chk = 0, n_fail = 0;
    ifetch_ctrl dut (
        .clk(clk), .reset(reset), .pc_next(pc_next), .pc_stall(pc_stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_stall(id_stall), .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        reset = 1'b1; imem_ready = 1'b0; redirect_valid = 1'b0; id_stall = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        #1;
    endtask
    task automatic test_reset();
        do_reset();
        n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_req: got %b want 1", imem_req); end
        n_chk++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        n_chk++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        n_chk++; if (pc_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got %b want 1", pc_stall); end
        n_chk++; if (pc_next !== 32'h0) begin n_fail++; $display("FAIL reset_pc_next: got %h want 0", pc_next); end
    endtask
    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            imem_ready = 1'b1; imem_rdata = 32'hC0DE_0000 + 32'(i);
            #1;
            n_chk++; if (imem_addr !== 32'(i * 4)) begin n_fail++; $display("FAIL stream_addr%0d: got %h want %h", i, imem_addr, 32'(i * 4)); end
            tick();
            n_chk++; if (pc_next !== 32'(i * 4 + 4)) begin n_fail++; $display("FAIL stream_pc_next%0d: got %h want %h", i, pc_next, 32'(i * 4 + 4)); end
            n_chk++; if (pc_stall !== 1'b0) begin n_fail++; $display("FAIL stream_stall%0d: got %b want 0", i, pc_stall); end
            n_chk++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid%0d: got %b want 1", i, inst_valid); end
            n_chk++; if (inst_pc !== 32'(i * 4)) begin n_fail++; $display("FAIL stream_inst_pc%0d: got %h want %h", i, inst_pc, 32'(i * 4)); end
            n_chk++; if (inst_out !== 32'hC0DE_0000 + 32'(i)) begin n_fail++; $display("FAIL stream_inst%0d: got %h want %h", i, inst_out, 32'hC0DE_0000 + 32'(i)); end
        end
        imem_ready = 1'b0;
    endtask
    task automatic test_backpressure();
        do_reset();
        id_stall = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h1111_0000;
        tick();
        imem_rdata = 32'h1111_0004;
        tick();
        imem_ready = 1'b0;
        #1;
        n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_hold_req: got %b want 0", imem_req); end
        n_chk++; if (pc_next !== 32'h8) begin n_fail++; $display("FAIL bp_fetch_pc: got %h want 8", pc_next); end
        n_chk++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head_pc: got %h want 0", inst_pc); end
        tick();
        n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_hold_req2: got %b want 0", imem_req); end
        id_stall = 1'b0;
        #1;
        n_chk++; if (inst_out !== 32'h1111_0000) begin n_fail++; $display("FAIL bp_pop0: got %h want 11110000", inst_out); end
        tick();
        n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL bp_req_again: got %b want 1", imem_req); end
        n_chk++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL bp_addr8: got %h want 8", imem_addr); end
        n_chk++; if (inst_pc !== 32'h4) begin n_fail++; $display("FAIL bp_pop1_pc: got %h want 4", inst_pc); end
        tick();
        n_chk++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", inst_valid); end
    endtask
    task automatic test_redirect_wait();
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        n_chk++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rw_valid: got %b want 0", inst_valid); end
        tick();
        redirect_valid = 1'b0;
        #1;
        n_chk++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rw_hold1: got %h want 0", imem_addr); end
        tick();
        imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        n_chk++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rw_hold2: got %h want 0", imem_addr); end
        tick();
        imem_ready = 1'b0;
        #1;
        n_chk++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rw_dropped: got %b want 0", inst_valid); end
        n_chk++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL rw_target: got %h want 100", imem_addr); end
        n_chk++; if (pc_next !== 32'h100) begin n_fail++; $display("FAIL rw_pc_next: got %h want 100", pc_next); end
        n_chk++; if (pc_stall !== 1'b0) begin n_fail++; $display("FAIL rw_stall: got %b want 0", pc_stall); end
    endtask
    task automatic test_double_redirect();
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0BAD_0BAD;
        tick();
        imem_rdata = 32'h3333_3333;
        #1;
        n_chk++; if (imem_addr !== 32'h300) begin n_fail++; $display("FAIL dr_addr: got %h want 300", imem_addr); end
        tick();
        imem_ready = 1'b0;
        #1;
        n_chk++; if (inst_pc !== 32'h300) begin n_fail++; $display("FAIL dr_inst_pc: got %h want 300", inst_pc); end
        n_chk++; if (inst_out !== 32'h3333_3333) begin n_fail++; $display("FAIL dr_inst: got %h want 33333333", inst_out); end
    endtask
    task automatic test_redirect_pop();
        do_reset();
        id_stall = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h5555_0000;
        tick();
        id_stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h400;
        #1;
        n_chk++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rp_valid_forced: got %b want 0", inst_valid); end
        tick();
        redirect_valid = 1'b0; imem_ready = 1'b0;
        #1;
        n_chk++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rp_flushed: got %b want 0", inst_valid); end
        n_chk++; if (imem_addr !== 32'h400) begin n_fail++; $display("FAIL rp_addr: got %h want 400", imem_addr); end
        n_chk++; if (pc_next !== 32'h400) begin n_fail++; $display("FAIL rp_pc_next: got %h want 400", pc_next); end
    endtask
    task automatic test_wrap();
        do_reset();
        imem_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0; imem_rdata = 32'h7777_7777;
        #1;
        n_chk++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr: got %h want fffffffc", imem_addr); end
        tick();
        imem_ready = 1'b0;
        #1;
        n_chk++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_zero: got %h want 0", imem_addr); end
        n_chk++; if (inst_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_inst_pc: got %h want fffffffc", inst_pc); end
    endtask
    task automatic test_reset_mid();
        do_reset();
        imem_ready = 1'b1; imem_rdata = 32'h9999_0000;
        tick();
        imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h500;
        tick();
        redirect_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_chk++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rm_addr: got %h want 0", imem_addr); end
        n_chk++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rm_empty: got %b want 0", inst_valid); end
        n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rm_req: got %b want 1", imem_req); end
        imem_ready = 1'b1; imem_rdata = 32'hAAAA_0000;
        tick();
        imem_ready = 1'b0;
        #1;
        n_chk++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin n_fail++; $display("FAIL rm_push: got valid %b pc %h want 1 0", inst_valid, inst_pc); end
        n_chk++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL rm_next: got %h want 4", imem_addr); end
    endtask
    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_double_redirect();
        test_redirect_pop();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
